instr_queue_writer: RTL and testbench
=====================================

Name: instr_queue_writer

Overview:
- Write-side producer for the instruction queue, the counterpart of the queue's read port (re/empty, dma_instr/arithmetic_instr/cache_instr).
- Accepts a byte stream from the program loader over a valid/ready handshake and assembles 5-byte little-endian instruction words.
- Splits each word into dma/arithmetic/cache fields and writes it into the queue with we/full flow control.
- Asserts done after the instruction flagged last has been written.

Parameters:
- DMA_BITS, 22, width of dma instruction field
- ARITH_BITS, 1, width of arithmetic instruction field
- CACHE_BITS, 17, width of cache instruction field
- INSTR_BYTES, 5, bytes per instruction (must equal ceil((DMA_BITS+ARITH_BITS+CACHE_BITS)/8))
- CNT_BITS, 16, width of instruction counter

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (0 = in reset)
- in_valid  in  1  loader byte valid
- in_data  in  8  loader byte
- in_last  in  1  qualifies the final byte of the program
- in_ready  out  1  writer accepts a byte this cycle
- q_we  out  1  queue write enable; the queue captures on the rising edge
- q_dma_instr  out  DMA_BITS  word[39:18]
- q_arithmetic_instr  out  ARITH_BITS  word[17]
- q_cache_instr  out  CACHE_BITS  word[16:0]
- q_full  in  1  queue full; a write is blocked while high
- instr_count  out  CNT_BITS  instructions written, saturating
- done  out  1  program fully written (sticky)
- err  out  1  malformed stream (sticky)

Behaviour:
- Byte packing: byte k fills word bits [8k+7:8k]; byte 0 first.
- Handshake: a byte transfers on a rising edge with in_valid && in_ready. While in_ready=0 the source holds its data; in_valid alone is ignored.
- FSM states: COLLECT, WRITE, DONE, ERR. Reset state is COLLECT with idx=0.
- COLLECT:
  - in_ready=1, q_we=0.
  - Each accepted byte stores at idx, then idx++.
  - Accepting byte idx=INSTR_BYTES-1 goes to WRITE and latches last_r=in_last.
  - in_last on any earlier byte goes to ERR; the partial word is discarded.
- WRITE:
  - in_ready=0.
  - Field outputs are registered and stable for the whole state.
  - q_we = !q_full (combinational).
  - If !q_full on an edge: instr_count++ (saturates at all-ones), idx cleared, next state is DONE if last_r else COLLECT.
  - If q_full: remain in WRITE with no loss and no duplicate write.
- DONE: done=1, in_ready=0, q_we=0. Held until reset.
- ERR: err=1, in_ready=0, q_we=0. Held until reset.
- Latency: the 5th byte is accepted at edge N; q_we is high during cycle N+1 when q_full=0. Minimum cost is 6 cycles per instruction.
- Reset values: in_ready=1 (COLLECT), q_we=0, all field outputs 0, instr_count=0, done=0, err=0.
- Reset asserted mid-collection or mid-WRITE discards any partial or pending word immediately; no q_we pulse is generated.
- Fields never change while q_we=1.

Optional Feature:
- Macro: INSTR_WRITER_PARITY_EN.
- Defined:
  - Each instruction carries INSTR_BYTES+1 bytes; the extra byte's bit0 is the even parity of the 40 payload bits.
  - Parity mismatch goes to ERR with no write.
  - in_last belongs on the parity byte; in_last on any earlier byte goes to ERR.
- Undefined: exactly INSTR_BYTES bytes per instruction; no parity check.

Decomposition:
- Package instr_queue_pkg holds:
  - DMA_BITS, ARITH_BITS, CACHE_BITS, INSTR_BYTES constants
  - packed struct instr_t {dma, arith, cache}, shared with the queue
  - writer state enum
- Sub-module instr_byte_packer: byte-index counter and shift/store register producing instr_t plus a word_complete strobe. The FSM, handshake and counters live in the top module.

Test Plan:
1. Bytes 01,02,03,04,85 with in_last on the 5th, q_full=0 -> one q_we pulse with dma=0x214100, arith=1, cache=0x10201; instr_count=1; done=1 on the following cycle.
2. Same as 1 with q_full=1 for 10 cycles after the 5th byte -> q_we=0, in_ready=0, fields stable; q_full drops -> exactly one q_we, count=1.
3. Three instructions (15 bytes) with in_valid continuous and q_full=0 -> q_we pulses spaced 6 cycles apart; count=3; done after the 3rd.
4. in_last on the 3rd byte -> err=1, q_we never asserted, in_ready=0, count=0.
5. reset low after 3 bytes, then 5 fresh bytes AA,BB,CC,DD,EE -> a single write of word 0xEEDDCCBBAA; no trace of the earlier bytes.
6. With INSTR_WRITER_PARITY_EN: correct parity byte -> write occurs; flipped parity -> err=1, no q_we.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// Shared types and constants for the instruction queue and its write-side producer.
// INSTR_WRITER_PARITY_EN adds a trailing even-parity byte to every instruction.
package instr_queue_pkg;

  localparam int DMA_BITS    = 22;
  localparam int ARITH_BITS  = 1;
  localparam int CACHE_BITS  = 17;
  localparam int INSTR_BYTES = 5;
  localparam int WORD_BITS   = DMA_BITS + ARITH_BITS + CACHE_BITS;

`ifdef INSTR_WRITER_PARITY_EN
  localparam int XFER_BYTES  = INSTR_BYTES + 1;
`else
  localparam int XFER_BYTES  = INSTR_BYTES;
`endif

  localparam int IDX_BITS    = 3;

  typedef struct packed {
    logic [DMA_BITS-1:0]   dma;
    logic [ARITH_BITS-1:0] arith;
    logic [CACHE_BITS-1:0] cache;
  } instr_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_WRITE   = 2'd1,
    ST_DONE    = 2'd2,
    ST_ERR     = 2'd3
  } writer_state_e;

endpackage

// File: rtl/instr_queue_writer_if.sv
// Loader byte stream (valid/ready) plus queue write port (we/full) seen by the writer.
// Byte transfer: in_valid && in_ready at a rising edge. Queue write: q_we at a rising edge.
interface instr_queue_writer_if;
  import instr_queue_pkg::*;

  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  q_we;
  logic [DMA_BITS-1:0]   q_dma_instr;
  logic [ARITH_BITS-1:0] q_arithmetic_instr;
  logic [CACHE_BITS-1:0] q_cache_instr;
  logic                  q_full;

  modport master (
    input  in_valid, in_data, in_last, q_full,
    output in_ready, q_we, q_dma_instr, q_arithmetic_instr, q_cache_instr
  );

  modport slave (
    output in_valid, in_data, in_last, q_full,
    input  in_ready, q_we, q_dma_instr, q_arithmetic_instr, q_cache_instr
  );
endinterface

// File: rtl/instr_queue_writer_byte_packer.sv
// Little-endian byte collector: byte k lands in word bits [8k+7:8k].
// instr_o already includes the byte being accepted, so it is valid with word_complete_o.
module instr_byte_packer
  import instr_queue_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       accept_i,
  input  logic [7:0] byte_i,
  output instr_t     instr_o,
  output logic       word_complete_o
);

  localparam logic [IDX_BITS-1:0] LAST_IDX  = IDX_BITS'(XFER_BYTES - 1);
  localparam logic [IDX_BITS-1:0] PAY_BYTES = IDX_BITS'(INSTR_BYTES);

  logic [IDX_BITS-1:0]              idx_q;
  logic [INSTR_BYTES-1:0][7:0]      bytes_q;
  logic [INSTR_BYTES-1:0][7:0]      bytes_d;

  always_comb begin
    bytes_d = bytes_q;
    if (accept_i && (idx_q < PAY_BYTES)) begin
      bytes_d[idx_q] = byte_i;
    end
  end

  assign word_complete_o = accept_i && (idx_q == LAST_IDX);
  assign instr_o         = instr_t'(bytes_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      bytes_q <= '0;
    end else if (accept_i) begin
      bytes_q <= bytes_d;
      idx_q   <= word_complete_o ? '0 : idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/instr_queue_writer.sv
// Write-side producer for the instruction queue: packs loader bytes into instr_t words
// and writes them with we/full flow control. Optional parity: INSTR_WRITER_PARITY_EN.
module instr_queue_writer
  import instr_queue_pkg::*;
#(
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  instr_queue_writer_if.master bus,
  output logic [CNT_BITS-1:0] instr_count,
  output logic                done,
  output logic                err,
  output writer_state_e       dbg_state_o
);

  writer_state_e       state_q;
  logic                in_ready_q;
  logic                last_q;
  logic                done_q;
  logic                err_q;
  logic [CNT_BITS-1:0] instr_count_q;
  instr_t              fields_q;

  instr_t instr_w;
  logic   word_complete_w;
  logic   accept_w;
  logic   par_ok_w;

  assign accept_w = bus.in_valid && in_ready_q;

  instr_byte_packer u_packer (
    .clk             (clk),
    .reset           (reset),
    .accept_i        (accept_w),
    .byte_i          (bus.in_data),
    .instr_o         (instr_w),
    .word_complete_o (word_complete_w)
  );

`ifdef INSTR_WRITER_PARITY_EN
  assign par_ok_w = ((^instr_w) == bus.in_data[0]);
`else
  assign par_ok_w = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_COLLECT;
      in_ready_q    <= 1'b1;
      last_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      instr_count_q <= '0;
      fields_q      <= '0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (accept_w) begin
            if (word_complete_w) begin
              in_ready_q <= 1'b0;
              if (par_ok_w) begin
                fields_q <= instr_w;
                last_q   <= bus.in_last;
                state_q  <= ST_WRITE;
              end else begin
                err_q   <= 1'b1;
                state_q <= ST_ERR;
              end
            end else if (bus.in_last) begin
              // Program ended mid-word: drop the partial word.
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
              state_q    <= ST_ERR;
            end
          end
        end
        ST_WRITE: begin
          if (!bus.q_full) begin
            if (instr_count_q != '1) begin
              instr_count_q <= instr_count_q + 1'b1;
            end
            if (last_q) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= ST_COLLECT;
            end
          end
        end
        ST_DONE: state_q <= ST_DONE;
        ST_ERR:  state_q <= ST_ERR;
        default: state_q <= ST_ERR;
      endcase
    end
  end

  assign bus.in_ready           = in_ready_q;
  assign bus.q_we               = (state_q == ST_WRITE) && !bus.q_full;
  assign bus.q_dma_instr        = fields_q.dma;
  assign bus.q_arithmetic_instr = fields_q.arith;
  assign bus.q_cache_instr      = fields_q.cache;
  assign instr_count            = instr_count_q;
  assign done                   = done_q;
  assign err                    = err_q;
  assign dbg_state_o            = state_q;

endmodule

// File: tb/tb_instr_queue_writer.sv
// Self-checking bench for instr_queue_writer: expected words are queued as bytes are driven
// and compared when q_we fires. Builds with or without INSTR_WRITER_PARITY_EN.
module tb_instr_queue_writer;
  import instr_queue_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_queue_writer_if bus();
  logic [15:0]   instr_count;
  logic          done;
  logic          err;
  writer_state_e dbg_state;

  instr_queue_writer dut (
    .clk         (clk),
    .reset       (rst_n),
    .bus         (bus),
    .instr_count (instr_count),
    .done        (done),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int we_count = 0;
  int we_cyc[$];
  logic [WORD_BITS-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every queue write must match the oldest outstanding instruction.
  always @(negedge clk) begin
    if (rst_n && bus.q_we) begin
      logic [WORD_BITS-1:0] w;
      we_count++;
      we_cyc.push_back(cyc);
      check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("sb_dma",   64'(bus.q_dma_instr),        64'(w[39:18]));
        check("sb_arith", 64'(bus.q_arithmetic_instr), 64'(w[17]));
        check("sb_cache", 64'(bus.q_cache_instr),      64'(w[16:0]));
      end
    end
  end

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    bus.q_full   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int   tries = 0;
    logic ok    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (!ok && tries < 50) begin
      @(negedge clk);
      ok = bus.in_ready;
      tries++;
    end
    if (!ok) check("ready_timeout", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_instr(input logic [WORD_BITS-1:0] w, input logic l,
                            input logic push, input logic bad_par);
    if (push) exp_q.push_back(w);
`ifdef INSTR_WRITER_PARITY_EN
    for (int i = 0; i < INSTR_BYTES; i++) send_byte(w[8*i +: 8], 1'b0);
    send_byte({7'b0, (^w) ^ bad_par}, l);
`else
    for (int i = 0; i < INSTR_BYTES; i++)
      send_byte(w[8*i +: 8], (i == INSTR_BYTES - 1) ? l : 1'b0);
    if (bad_par) check("parity_unsupported", 64'(bad_par), 64'd0);
`endif
  endtask

  task automatic wait_we(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.q_we && n < 100);
    if (!bus.q_we) check("we_timeout", 64'(bus.q_we), 64'd1);
  endtask

  initial begin
    int n;
    int base_we;
    int base_idx;

    // Reset values
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_q_we",     64'(bus.q_we), 64'd0);
    check("rst_dma",      64'(bus.q_dma_instr), 64'd0);
    check("rst_arith",    64'(bus.q_arithmetic_instr), 64'd0);
    check("rst_cache",    64'(bus.q_cache_instr), 64'd0);
    check("rst_count",    64'(instr_count), 64'd0);
    check("rst_done",     64'(done), 64'd0);
    check("rst_err",      64'(err), 64'd0);
    check("rst_state",    64'(dbg_state), 64'(ST_COLLECT));
    do_reset();

    // 1: single instruction, last flagged
    send_instr(40'h85_04_03_02_01, 1'b1, 1'b1, 1'b0);
    wait_we(n);
    check("t1_latency", 64'(n), 64'd1);
    check("t1_dma",   64'(bus.q_dma_instr), 64'h214100);
    check("t1_arith", 64'(bus.q_arithmetic_instr), 64'd1);
    check("t1_cache", 64'(bus.q_cache_instr), 64'h10201);
    check("t1_ready_in_write", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check("t1_done",  64'(done), 64'd1);
    check("t1_count", 64'(instr_count), 64'd1);
    check("t1_we_off", 64'(bus.q_we), 64'd0);
    check("t1_ready_off", 64'(bus.in_ready), 64'd0);

    // 2: queue full for 10 cycles after the last byte
    do_reset();
    base_we = we_count;
    bus.q_full = 1'b1;
    send_instr(40'h85_04_03_02_01, 1'b1, 1'b1, 1'b0);
    repeat (10) begin
      @(negedge clk);
      check("t2_we_blocked", 64'(bus.q_we), 64'd0);
      check("t2_ready",      64'(bus.in_ready), 64'd0);
      check("t2_dma_stable", 64'(bus.q_dma_instr), 64'h214100);
    end
    @(posedge clk);
    #1 bus.q_full = 1'b0;
    wait_we(n);
    check("t2_wait", 64'(n), 64'd1);
    repeat (3) @(negedge clk);
    check("t2_one_write", 64'(we_count - base_we), 64'd1);
    check("t2_count", 64'(instr_count), 64'd1);
    check("t2_done",  64'(done), 64'd1);

    // 3: three back-to-back instructions
    do_reset();
    base_we  = we_count;
    base_idx = we_cyc.size();
    send_instr(40'h12_34_56_78_9A, 1'b0, 1'b1, 1'b0);
    send_instr(40'hFF_00_FF_00_FF, 1'b0, 1'b1, 1'b0);
    send_instr(40'h01_23_45_67_89, 1'b1, 1'b1, 1'b0);
    wait_we(n);
    @(negedge clk);
    check("t3_writes", 64'(we_count - base_we), 64'd3);
    check("t3_count",  64'(instr_count), 64'd3);
    check("t3_done",   64'(done), 64'd1);
    if (we_cyc.size() >= base_idx + 3) begin
      check("t3_gap01", 64'(we_cyc[base_idx+1] - we_cyc[base_idx]),   64'(XFER_BYTES + 1));
      check("t3_gap12", 64'(we_cyc[base_idx+2] - we_cyc[base_idx+1]), 64'(XFER_BYTES + 1));
    end else begin
      check("t3_gap_samples", 64'(we_cyc.size() - base_idx), 64'd3);
    end

    // 4: in_last on the 3rd byte
    do_reset();
    base_we = we_count;
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b1);
    @(negedge clk);
    check("t4_err",   64'(err), 64'd1);
    check("t4_ready", 64'(bus.in_ready), 64'd0);
    check("t4_state", 64'(dbg_state), 64'(ST_ERR));
    repeat (5) @(negedge clk);
    check("t4_no_we", 64'(we_count - base_we), 64'd0);
    check("t4_count", 64'(instr_count), 64'd0);
    check("t4_done",  64'(done), 64'd0);

    // Reset while a write is pending behind a full queue
    do_reset();
    base_we = we_count;
    bus.q_full = 1'b1;
    send_instr(40'h55_44_33_22_11, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    bus.q_full = 1'b0;
    @(negedge clk);
    check("rw_we_low",  64'(bus.q_we), 64'd0);
    check("rw_dma_clr", 64'(bus.q_dma_instr), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rw_no_we", 64'(we_count - base_we), 64'd0);

    // 5: reset after 3 bytes, then a fresh instruction
    do_reset();
    base_we = we_count;
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_ready_rst", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_instr(40'hEE_DD_CC_BB_AA, 1'b1, 1'b1, 1'b0);
    wait_we(n);
    check("t5_latency", 64'(n), 64'd1);
    check("t5_word", {24'd0, bus.q_dma_instr, bus.q_arithmetic_instr, bus.q_cache_instr},
          64'hEE_DD_CC_BB_AA);
    @(negedge clk);
    check("t5_one_write", 64'(we_count - base_we), 64'd1);
    check("t5_count", 64'(instr_count), 64'd1);

`ifdef INSTR_WRITER_PARITY_EN
    // 6: parity good then parity flipped
    do_reset();
    base_we = we_count;
    send_instr(40'h0F_1E_2D_3C_4B, 1'b1, 1'b1, 1'b0);
    wait_we(n);
    check("t6_good_latency", 64'(n), 64'd1);
    @(negedge clk);
    check("t6_good_done", 64'(done), 64'd1);
    do_reset();
    base_we = we_count;
    send_instr(40'h0F_1E_2D_3C_4B, 1'b1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check("t6_bad_err",  64'(err), 64'd1);
    check("t6_bad_no_we", 64'(we_count - base_we), 64'd0);
    check("t6_bad_count", 64'(instr_count), 64'd0);
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
